// File: rtl/instruction_fetch_pkg.sv
// Shared encodings for the uDLX instruction fetch stage: FSM states,
// PC next-value selects and the NOP word loaded on a bubble.
package instruction_fetch_pkg;

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_e;

    typedef enum logic [1:0] {
        PC_KEEP    = 2'd0,
        PC_SEQ_REQ = 2'd1,
        PC_SEQ_PC  = 2'd2,
        PC_TARGET  = 2'd3
    } pc_sel_e;

    // Wide enough for any instruction width in use; sliced at the top.
    localparam logic [63:0] NOP_INST = '0;

endpackage

// File: rtl/instruction_fetch_pc_unit.sv
// Program counter and outstanding request address: incrementers plus the
// redirect mux. req_addr always loads the same value pc_reg is loading.
module instruction_fetch_pc_unit
    import instruction_fetch_pkg::*;
#(
    parameter int PC_DATA_WIDTH = 20,
    parameter int RESET_PC      = 0,
    parameter int PC_INCREMENT  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [1:0]               i_pc_sel,
    input  logic                     i_req_load,
    input  logic [PC_DATA_WIDTH-1:0] i_target,
    output logic [PC_DATA_WIDTH-1:0] o_req_addr,
    output logic [PC_DATA_WIDTH-1:0] o_pc_inc,
    output logic [PC_DATA_WIDTH-1:0] o_req_inc
);

    localparam logic [PC_DATA_WIDTH-1:0] RST_PC = PC_DATA_WIDTH'(RESET_PC);
    localparam logic [PC_DATA_WIDTH-1:0] INC    = PC_DATA_WIDTH'(PC_INCREMENT);

    logic [PC_DATA_WIDTH-1:0] r_pc;
    logic [PC_DATA_WIDTH-1:0] r_req_addr;
    logic [PC_DATA_WIDTH-1:0] w_pc_next;

    // Plain modulo-2^N adds: wrap past the top of memory is intended.
    assign o_pc_inc   = r_pc + INC;
    assign o_req_inc  = r_req_addr + INC;
    assign o_req_addr = r_req_addr;

    always_comb begin
        w_pc_next = r_pc;
        case (i_pc_sel)
            PC_SEQ_REQ: w_pc_next = o_req_inc;
            PC_SEQ_PC:  w_pc_next = o_pc_inc;
            PC_TARGET:  w_pc_next = i_target;
            default:    w_pc_next = r_pc;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc       <= RST_PC;
            r_req_addr <= RST_PC;
        end else begin
            r_pc <= w_pc_next;
            if (i_req_load)
                r_req_addr <= w_pc_next;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// uDLX fetch stage: SRAM read handshake FSM, redirect kill flag and the
// one-entry hold buffer used while the hazard unit stalls fetch/decode.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int PC_DATA_WIDTH     = 20,
    parameter int INSTRUCTION_WIDTH = 32,
    parameter int RESET_PC          = 0,
    parameter int PC_INCREMENT      = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         stall,
    input  logic                         branch_taken,
    input  logic [PC_DATA_WIDTH-1:0]     branch_target,
    output logic                         inst_mem_rd_en,
    output logic [PC_DATA_WIDTH-1:0]     inst_mem_addr,
    input  logic                         inst_mem_ready,
    input  logic [INSTRUCTION_WIDTH-1:0] inst_mem_data_in,
    output logic [INSTRUCTION_WIDTH-1:0] instruction_out,
    output logic [PC_DATA_WIDTH-1:0]     pc_out,
    output logic                         flush_out
);

    localparam logic [INSTRUCTION_WIDTH-1:0] NOP = NOP_INST[INSTRUCTION_WIDTH-1:0];

    fetch_state_e                   r_state, w_state_next;
    logic                           r_kill, w_kill_next;
    logic [INSTRUCTION_WIDTH-1:0]   r_hold_inst;
    logic                           w_hold_load;
    pc_sel_e                        w_pc_sel;
    logic                           w_req_load;
    logic [PC_DATA_WIDTH-1:0]       w_req_addr, w_pc_inc, w_req_inc;

    instruction_fetch_pc_unit #(
        .PC_DATA_WIDTH (PC_DATA_WIDTH),
        .RESET_PC      (RESET_PC),
        .PC_INCREMENT  (PC_INCREMENT)
    ) u_pc_unit (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_pc_sel   (w_pc_sel),
        .i_req_load (w_req_load),
        .i_target   (branch_target),
        .o_req_addr (w_req_addr),
        .o_pc_inc   (w_pc_inc),
        .o_req_inc  (w_req_inc)
    );

    assign inst_mem_addr = w_req_addr;

    always_comb begin
        w_state_next    = r_state;
        w_kill_next     = r_kill;
        w_hold_load     = 1'b0;
        w_pc_sel        = PC_KEEP;
        w_req_load      = 1'b0;
        inst_mem_rd_en  = 1'b0;
        flush_out       = 1'b1;
        instruction_out = NOP;
        pc_out          = w_pc_inc;
        case (r_state)
            S_BOOT: begin
                w_req_load   = 1'b1;
                w_state_next = S_REQ;
            end
            S_REQ: begin
                inst_mem_rd_en = 1'b1;
                if (!inst_mem_ready) begin
                    // Address must stay put; remember to drop this word.
                    if (branch_taken) begin
                        w_pc_sel    = PC_TARGET;
                        w_kill_next = 1'b1;
                    end
                end else if (r_kill || branch_taken) begin
                    w_kill_next = 1'b0;
                    w_pc_sel    = branch_taken ? PC_TARGET : PC_KEEP;
                    w_req_load  = 1'b1;
                end else begin
                    instruction_out = inst_mem_data_in;
                    pc_out          = w_req_inc;
                    flush_out       = 1'b0;
                    if (stall) begin
                        w_hold_load  = 1'b1;
                        w_state_next = S_HOLD;
                    end else begin
                        w_pc_sel   = PC_SEQ_REQ;
                        w_req_load = 1'b1;
                    end
                end
            end
            S_HOLD: begin
                instruction_out = r_hold_inst;
                flush_out       = 1'b0;
                if (branch_taken) begin
                    flush_out    = 1'b1;
                    w_pc_sel     = PC_TARGET;
                    w_req_load   = 1'b1;
                    w_state_next = S_REQ;
                end else if (!stall) begin
                    w_pc_sel     = PC_SEQ_PC;
                    w_req_load   = 1'b1;
                    w_state_next = S_REQ;
                end
            end
            default: w_state_next = S_BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_BOOT;
            r_kill      <= 1'b0;
            r_hold_inst <= '0;
        end else begin
            r_state <= w_state_next;
            r_kill  <= w_kill_next;
            if (w_hold_load)
                r_hold_inst <= inst_mem_data_in;
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed walk through the fetch scenarios, then a randomized run scored
// against a program-order model: next expected address, redirected by branches.
module tb_instruction_fetch;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        branch_taken;
    logic [19:0] branch_target;
    logic        inst_mem_rd_en;
    logic [19:0] inst_mem_addr;
    logic        inst_mem_ready;
    logic [31:0] inst_mem_data_in;
    logic [31:0] instruction_out;
    logic [19:0] pc_out;
    logic        flush_out;

    int checks   = 0;
    int failures = 0;

    instruction_fetch #(
        .PC_DATA_WIDTH     (20),
        .INSTRUCTION_WIDTH (32),
        .RESET_PC          (0),
        .PC_INCREMENT      (4)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .stall            (stall),
        .branch_taken     (branch_taken),
        .branch_target    (branch_target),
        .inst_mem_rd_en   (inst_mem_rd_en),
        .inst_mem_addr    (inst_mem_addr),
        .inst_mem_ready   (inst_mem_ready),
        .inst_mem_data_in (inst_mem_data_in),
        .instruction_out  (instruction_out),
        .pc_out           (pc_out),
        .flush_out        (flush_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM contents: each word tagged with its own address, never all-zero.
    function automatic logic [31:0] mem_word(input logic [19:0] a);
        return {~a[11:0], a};
    endfunction

    assign inst_mem_data_in = mem_word(inst_mem_addr);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rdy, input logic stl, input logic br, input logic [19:0] tgt);
        inst_mem_ready = rdy;
        stall          = stl;
        branch_taken   = br;
        branch_target  = tgt;
    endtask

    task automatic deliver(input string tag, input logic [19:0] a);
        logic [19:0] npc;
        npc = a + 20'd4;
        drive(1'b1, 1'b0, 1'b0, 20'h0);
        @(negedge clk);
        chk({tag, "_rd"},   32'(inst_mem_rd_en), 32'd1);
        chk({tag, "_addr"}, 32'(inst_mem_addr), 32'(a));
        chk({tag, "_fl"},   32'(flush_out), 32'd0);
        chk({tag, "_inst"}, instruction_out, mem_word(a));
        chk({tag, "_pc"},   32'(pc_out), 32'(npc));
        next_cycle();
    endtask

    initial begin
        logic [19:0] exp_addr, exp_pc, prev_addr;
        logic        prev_wait;
        int          consumed;

        rst_n = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 20'h0);
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_rd",   32'(inst_mem_rd_en), 32'd0);
        chk("rst_fl",   32'(flush_out), 32'd1);
        chk("rst_inst", instruction_out, 32'd0);
        chk("rst_pc",   32'(pc_out), 32'h4);
        next_cycle();
        rst_n = 1'b1;

        // boot cycle, then back-to-back fetch
        @(negedge clk);
        chk("boot_fl", 32'(flush_out), 32'd1);
        chk("boot_rd", 32'(inst_mem_rd_en), 32'd0);
        next_cycle();
        for (int a = 0; a < 16; a += 4) deliver("seq", 20'(a));

        // two wait states at 0x10
        for (int w = 0; w < 2; w++) begin
            drive(1'b0, 1'b0, 1'b0, 20'h0);
            @(negedge clk);
            chk("wait_fl",   32'(flush_out), 32'd1);
            chk("wait_rd",   32'(inst_mem_rd_en), 32'd1);
            chk("wait_addr", 32'(inst_mem_addr), 32'h10);
            next_cycle();
        end
        for (int a = 16'h10; a < 16'h20; a += 4) deliver("post_wait", 20'(a));

        // stall capture at 0x20
        drive(1'b1, 1'b1, 1'b0, 20'h0);
        @(negedge clk);
        chk("cap_addr", 32'(inst_mem_addr), 32'h20);
        next_cycle();
        for (int s = 0; s < 3; s++) begin
            drive(1'b1, 1'b1, 1'b0, 20'h0);
            @(negedge clk);
            chk("hold_rd",   32'(inst_mem_rd_en), 32'd0);
            chk("hold_inst", instruction_out, mem_word(20'h20));
            chk("hold_pc",   32'(pc_out), 32'h24);
            next_cycle();
        end
        drive(1'b1, 1'b0, 1'b0, 20'h0);
        @(negedge clk);
        chk("rel_fl",   32'(flush_out), 32'd0);
        chk("rel_inst", instruction_out, mem_word(20'h20));
        chk("rel_pc",   32'(pc_out), 32'h24);
        next_cycle();
        for (int a = 16'h24; a < 16'h40; a += 4) deliver("after_hold", 20'(a));

        // redirect while 0x40 is waiting
        drive(1'b0, 1'b0, 1'b1, 20'h100);
        @(negedge clk);
        chk("brw_fl",   32'(flush_out), 32'd1);
        chk("brw_addr", 32'(inst_mem_addr), 32'h40);
        next_cycle();
        drive(1'b0, 1'b0, 1'b0, 20'h0);
        @(negedge clk);
        chk("brw_stable", 32'(inst_mem_addr), 32'h40);
        chk("brw_rd",     32'(inst_mem_rd_en), 32'd1);
        next_cycle();
        drive(1'b1, 1'b0, 1'b0, 20'h0);
        @(negedge clk);
        chk("brw_discard", 32'(flush_out), 32'd1);
        next_cycle();
        deliver("brw_tgt", 20'h100);

        // redirect and stall together while holding 0x104
        drive(1'b1, 1'b1, 1'b0, 20'h0);
        @(negedge clk);
        next_cycle();
        drive(1'b1, 1'b1, 1'b1, 20'h100);
        @(negedge clk);
        chk("hbr_fl", 32'(flush_out), 32'd1);
        chk("hbr_rd", 32'(inst_mem_rd_en), 32'd0);
        next_cycle();
        deliver("hbr_tgt", 20'h100);

        // redirect to the top word, PC wraps to zero
        drive(1'b1, 1'b0, 1'b1, 20'hFFFFC);
        @(negedge clk);
        chk("wrap_br_fl", 32'(flush_out), 32'd1);
        next_cycle();
        deliver("wrap_top", 20'hFFFFC);
        deliver("wrap_zero", 20'h00000);

        // reset in the middle of a wait
        drive(1'b0, 1'b0, 1'b0, 20'h0);
        @(negedge clk);
        chk("mrst_pre_rd", 32'(inst_mem_rd_en), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mrst_rd", 32'(inst_mem_rd_en), 32'd0);
        chk("mrst_fl", 32'(flush_out), 32'd1);
        next_cycle();
        rst_n = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 20'h0);
        @(negedge clk);
        chk("mrst_boot", 32'(flush_out), 32'd1);
        next_cycle();
        deliver("mrst_restart", 20'h0);

        // randomized run against the program-order model
        exp_addr  = 20'h4;
        prev_wait = 1'b0;
        prev_addr = '0;
        consumed  = 0;
        for (int n = 0; n < 3000; n++) begin
            drive($urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 11) == 0, 20'($urandom) & 20'hFFFFC);
            @(negedge clk);
            if (prev_wait) begin
                chk("rnd_rd_hold",   32'(inst_mem_rd_en), 32'd1);
                chk("rnd_addr_hold", 32'(inst_mem_addr), 32'(prev_addr));
            end
            if (branch_taken) begin
                chk("rnd_br_fl", 32'(flush_out), 32'd1);
                exp_addr = branch_target;
            end else if (!stall && !flush_out) begin
                exp_pc = exp_addr + 20'd4;
                chk("rnd_inst", instruction_out, mem_word(exp_addr));
                chk("rnd_pc",   32'(pc_out), 32'(exp_pc));
                exp_addr = exp_pc;
                consumed++;
            end
            prev_wait = inst_mem_rd_en && !inst_mem_ready;
            prev_addr = inst_mem_addr;
            next_cycle();
        end
        chk("rnd_progress", 32'(consumed > 300), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
